// File: rtl/sramlike_mem_responder.sv
// sramlike_mem_responder
//   Responder end of an SRAM-like instruction/data port. It accepts byte-enabled
//   read/write requests, serves them from an internal word-organised memory and
//   returns one data_ok pulse per accepted request after READ_LATENCY edges.
//   An optional LFSR-driven mode withholds addr_ok pseudo-randomly so that the
//   master's backpressure handling gets exercised.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   ben      in   [3:0] byte enables; nonzero means a request is present
//   wr       in   1 = write, 0 = read
//   addr     in   [31:0] byte address; word index is addr[ADDR_WIDTH+1:2]
//   din      in   [31:0] write data, byte lane i = din[8i+7:8i]
//   stall    in   forces addr_ok low
//   addr_ok  out  request accepted on the coming edge
//   data_ok  out  one-cycle completion pulse
//   dout     out  [31:0] read data (32'h0 for write completions)

module sramlike_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 2,
    parameter bit          RAND_STALL   = 1'b0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  ben,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] dout
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Memory is deliberately not reset; contents survive a reset.
    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  req;
    logic                  rnd_block;
    logic                  unused_addr;

    logic [15:0] lfsr_q, lfsr_d;

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             dat_q [READ_LATENCY];
    logic [31:0]             dat_d [READ_LATENCY];

    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
    assign req         = (ben != 4'b0000);
    assign rnd_block   = RAND_STALL && (lfsr_q[1:0] == 2'b00);

    // Gated by reset so nothing is accepted (and nothing written) while in reset.
    assign addr_ok = req && !stall && !rnd_block && !reset;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Byte-lane write on the accept edge; untouched lanes keep their contents.
    always_ff @(posedge clock) begin
        if (addr_ok && wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ben[i]) begin
                    mem[idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Response shift pipeline: stage 0 captures the read word (or zero for a
    // write) on the accept edge; every stage advances each edge.
    always_comb begin
        vld_d = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            dat_d[i] = '0;
        end
        vld_d[0] = addr_ok;
        dat_d[0] = (addr_ok && !wr) ? mem[idx] : '0;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign data_ok = vld_q[READ_LATENCY-1];
    assign dout    = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sramlike_mem_responder.sv
module tb_sramlike_mem_responder;

    logic        clock;
    logic        reset;
    logic [3:0]  ben_a, ben_b, ben_c;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic        stall;
    logic        addr_ok_a, data_ok_a;
    logic        addr_ok_b, data_ok_b;
    logic        addr_ok_c, data_ok_c;
    logic [31:0] dout_a, dout_b, dout_c;

    int checks   = 0;
    int failures = 0;

    // a: latency 2, b: latency 3, c: latency 2 with random stall and a small memory
    sramlike_mem_responder #(.ADDR_WIDTH(12), .READ_LATENCY(2), .RAND_STALL(1'b0), .LFSR_SEED(16'hACE1)) dut_a (
        .clock(clock), .reset(reset), .ben(ben_a), .wr(wr), .addr(addr), .din(din), .stall(stall),
        .addr_ok(addr_ok_a), .data_ok(data_ok_a), .dout(dout_a));

    sramlike_mem_responder #(.ADDR_WIDTH(12), .READ_LATENCY(3), .RAND_STALL(1'b0), .LFSR_SEED(16'hACE1)) dut_b (
        .clock(clock), .reset(reset), .ben(ben_b), .wr(wr), .addr(addr), .din(din), .stall(stall),
        .addr_ok(addr_ok_b), .data_ok(data_ok_b), .dout(dout_b));

    sramlike_mem_responder #(.ADDR_WIDTH(6), .READ_LATENCY(2), .RAND_STALL(1'b1), .LFSR_SEED(16'hACE1)) dut_c (
        .clock(clock), .reset(reset), .ben(ben_c), .wr(wr), .addr(addr), .din(din), .stall(stall),
        .addr_ok(addr_ok_c), .data_ok(data_ok_c), .dout(dout_c));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic tick(input string tag, input int sel, input logic eao, input logic edo, input logic [31:0] edout);
        @(negedge clock);
        if (sel == 0) begin
            chk({tag, ".addr_ok"}, 32'(addr_ok_a), 32'(eao));
            chk({tag, ".data_ok"}, 32'(data_ok_a), 32'(edo));
            chk({tag, ".dout"}, dout_a, edout);
        end else begin
            chk({tag, ".addr_ok"}, 32'(addr_ok_b), 32'(eao));
            chk({tag, ".data_ok"}, 32'(data_ok_b), 32'(edo));
            chk({tag, ".dout"}, dout_b, edout);
        end
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    localparam int NOPS  = 1064;   // 64 initialising writes + 1000 random ops
    localparam int LIMIT = 30000;

    rsp_t        exp_q[$];
    logic [31:0] mref [64];
    int          cyc, issued, supp;
    logic        acc;
    logic [5:0]  widx;

    initial begin
        reset = 1'b1;
        ben_a = '0; ben_b = '0; ben_c = '0;
        wr = 1'b0; addr = '0; din = '0; stall = 1'b0;
        @(posedge clock); #1;

        // Reset: request present but acceptance gated, pipelines empty
        ben_a = 4'hF; wr = 1'b1; addr = 32'h100; din = 32'h12345678;
        tick("reset", 0, 1'b0, 1'b0, 32'h0);
        ben_a = '0;
        tick("reset2", 0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;

        // Write then read, latency 2
        ben_a = 4'hF; wr = 1'b1; addr = 32'h100; din = 32'hDEADBEEF;
        tick("wr100", 0, 1'b1, 1'b0, 32'h0);
        wr = 1'b0;
        tick("rd100", 0, 1'b1, 1'b0, 32'h0);
        ben_a = '0;
        tick("wr100_done", 0, 1'b0, 1'b1, 32'h0);
        tick("rd100_done", 0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick("idle1", 0, 1'b0, 1'b0, 32'h0);

        // Byte enables
        ben_a = 4'hF; wr = 1'b1; addr = 32'h40; din = 32'h11223344;
        tick("pre40", 0, 1'b1, 1'b0, 32'h0);
        ben_a = 4'b0101; din = 32'hAABBCCDD;
        tick("be40", 0, 1'b1, 1'b0, 32'h0);
        ben_a = 4'b0010; wr = 1'b0;
        tick("rd40", 0, 1'b1, 1'b1, 32'h0);
        ben_a = '0;
        tick("be40_done", 0, 1'b0, 1'b1, 32'h0);
        tick("rd40_done", 0, 1'b0, 1'b1, 32'h11BB33DD);
        tick("idle2", 0, 1'b0, 1'b0, 32'h0);

        // Back-to-back, latency 3
        for (int i = 0; i < 4; i++) begin
            ben_b = 4'hF; wr = 1'b1; addr = 32'(4 * i); din = 32'(i + 1);
            tick("b_pre", 1, 1'b1, (i == 3), 32'h0);
        end
        ben_b = '0;
        for (int i = 0; i < 3; i++) tick("b_pre_done", 1, 1'b0, 1'b1, 32'h0);
        tick("b_idle", 1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ben_b = 4'hF; wr = 1'b0; addr = 32'(4 * i);
            tick("b_rd", 1, 1'b1, (i == 3), (i == 3) ? 32'h1 : 32'h0);
        end
        ben_b = '0;
        for (int i = 0; i < 3; i++) tick("b_rd_done", 1, 1'b0, 1'b1, 32'(i + 2));
        tick("b_idle2", 1, 1'b0, 1'b0, 32'h0);

        // Stall with a read pending
        ben_a = 4'hF; wr = 1'b0; addr = 32'h100; stall = 1'b1;
        for (int i = 0; i < 5; i++) tick("stall", 0, 1'b0, 1'b0, 32'h0);
        stall = 1'b0;
        tick("stall_acc", 0, 1'b1, 1'b0, 32'h0);
        ben_a = '0;
        tick("stall_wait", 0, 1'b0, 1'b0, 32'h0);
        tick("stall_done", 0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick("idle3", 0, 1'b0, 1'b0, 32'h0);

        // Reset right after an accept drops the response
        ben_a = 4'hF; wr = 1'b0; addr = 32'h200;
        tick("rst_acc", 0, 1'b1, 1'b0, 32'h0);
        ben_a = '0; reset = 1'b1;
        tick("rst_mid1", 0, 1'b0, 1'b0, 32'h0);
        tick("rst_mid2", 0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick("rst_post1", 0, 1'b0, 1'b0, 32'h0);
        tick("rst_post2", 0, 1'b0, 1'b0, 32'h0);

        // Aliased address still reads the word written before reset
        ben_a = 4'h1; wr = 1'b0; addr = 32'h0000_4100;
        tick("alias_acc", 0, 1'b1, 1'b0, 32'h0);
        ben_a = '0;
        tick("alias_wait", 0, 1'b0, 1'b0, 32'h0);
        tick("alias_done", 0, 1'b0, 1'b1, 32'hDEADBEEF);

        // Random traffic with pseudo-random acceptance against a queue model
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        cyc = 0; issued = 0; supp = 0;
        while (!(issued == NOPS && ben_c == 4'h0 && exp_q.size() == 0) && cyc < LIMIT) begin
            @(negedge clock);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("rand.data_ok", 32'(data_ok_c), 32'h1);
                chk("rand.dout", dout_c, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("rand.no_data_ok", 32'(data_ok_c), 32'h0);
                chk("rand.dout_idle", dout_c, 32'h0);
            end
            acc = 1'b0;
            if (ben_c == 4'h0) begin
                chk("rand.addr_ok_noreq", 32'(addr_ok_c), 32'h0);
            end else if (!addr_ok_c) begin
                supp++;
            end else begin
                acc  = 1'b1;
                widx = addr[7:2];
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (ben_c[b]) mref[widx][8*b +: 8] = din[8*b +: 8];
                    exp_q.push_back('{due: cyc + 2, data: 32'h0});
                end else begin
                    exp_q.push_back('{due: cyc + 2, data: mref[widx]});
                end
            end
            @(posedge clock); #1;
            cyc++;
            if (acc || ben_c == 4'h0) begin
                if (issued < 64) begin
                    ben_c = 4'hF; wr = 1'b1; addr = 32'(4 * issued); din = $urandom;
                    issued++;
                end else if (issued < NOPS && $urandom_range(0, 3) != 0) begin
                    ben_c = 4'($urandom_range(1, 15));
                    wr = 1'($urandom_range(0, 1));
                    addr = $urandom;
                    din = $urandom;
                    issued++;
                end else begin
                    ben_c = '0;
                end
            end
        end
        chk("rand.issued", 32'(issued), 32'(NOPS));
        chk("rand.drained", 32'(exp_q.size()), 32'h0);
        chk("rand.suppression_seen", 32'(supp > 0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
